// File: rtl/dffn_chain_pkg.sv
// Shared types and default geometry for the falling-edge flop chain driver.
// Holds the transfer FSM state type and a counter-width helper.
package dffn_chain_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_HALF    = 2;
  localparam int DEF_CLR_CYC = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_FIN
  } state_t;

  // Bits needed for a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dffn_chain_if.sv
// Request/response side of the chain driver: start handshake, load word,
// unloaded word and status.
interface dffn_chain_if import dffn_chain_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start_valid;
  logic             start_ready;
  logic             clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             done;
  logic             busy;

  modport master (
    output start_valid, clr, din,
    input  start_ready, dout, done, busy
  );

  modport slave (
    input  start_valid, clr, din,
    output start_ready, dout, done, busy
  );

endinterface

// File: rtl/dffn_chain_phase_gen.sv
// Slot timing for the SHIFT state: phase and bit counters plus the registered
// CLKN strobe (high for the first HALF cycles of each slot, low for the rest).
module dffn_chain_phase_gen import dffn_chain_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HALF  = DEF_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic clkn_out,
  output logic fall,
  output logic slot_end,
  output logic last_slot
);

  localparam int PW = cnt_w(2 * HALF);
  localparam int BW = cnt_w(WIDTH);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic [BW-1:0] bit_idx;

  // The edge that ends the high half is the one that drives CLKN low.
  assign fall      = run && (phase == PW'(HALF - 1));
  assign slot_end  = run && (phase == PW'(2 * HALF - 1));
  assign last_slot = (bit_idx == BW'(WIDTH - 1));
  assign phase_nxt = slot_end ? '0 : phase + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order or process scheduling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      bit_idx  <= '0;
      clkn_out <= 1'b1;
    end else if (!run) begin
      phase    <= '0;
      bit_idx  <= '0;
      clkn_out <= 1'b1;
    end else begin
      phase    <= phase_nxt;
      clkn_out <= (phase_nxt < PW'(HALF));
      if (slot_end) begin
        bit_idx <= last_slot ? '0 : bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dffn_chain_driver.sv
// Drives an external chain of falling-edge flops: optional clear, MSB-first
// serial load, and simultaneous unload of the previous chain contents.
module dffn_chain_driver import dffn_chain_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HALF    = DEF_HALF,
  parameter int CLR_CYC = DEF_CLR_CYC
) (
  input  logic            clk,
  input  logic            rst,
  dffn_chain_if.slave     bus,
  output logic            sdo,
  output logic            clkn_out,
  output logic            rn_out,
  input  logic            si
);

  localparam int CW = cnt_w(CLR_CYC);

  state_t           state;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;
  logic [CW-1:0]    clr_cnt;
  logic             run;
  logic             fall;
  logic             slot_end;
  logic             last_slot;

  assign run = (state == ST_SHIFT);

  dffn_chain_phase_gen #(
    .WIDTH (WIDTH),
    .HALF  (HALF)
  ) u_phase_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .clkn_out  (clkn_out),
    .fall      (fall),
    .slot_end  (slot_end),
    .last_slot (last_slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      // NOTE: the shift registers are reset because the unloaded word must
      // read zero after reset; bulk storage without that need stays unreset.
      tx              <= '0;
      rx              <= '0;
      clr_cnt         <= '0;
      sdo             <= 1'b0;
      rn_out          <= 1'b1;
      bus.start_ready <= 1'b1;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.dout        <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            tx              <= bus.din;
            clr_cnt         <= '0;
            bus.start_ready <= 1'b0;
            bus.busy        <= 1'b1;
            if (bus.clr) begin
              state  <= ST_CLEAR;
              rn_out <= 1'b0;
              sdo    <= 1'b0;
            end else begin
              state <= ST_SHIFT;
              sdo   <= bus.din[WIDTH-1];
            end
          end
        end

        ST_CLEAR: begin
          if (clr_cnt == CW'(CLR_CYC - 1)) begin
            state  <= ST_SHIFT;
            rn_out <= 1'b1;
            sdo    <= tx[WIDTH-1];
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          // Capture the last flop before the falling strobe advances the chain.
          if (fall) begin
            rx <= {rx[WIDTH-2:0], si};
          end
          if (slot_end) begin
            tx <= tx << 1;
            if (last_slot) begin
              state    <= ST_FIN;
              sdo      <= 1'b0;
              bus.done <= 1'b1;
              bus.dout <= rx;
            end else begin
              sdo <= tx[WIDTH-2];
            end
          end
        end

        ST_FIN: begin
          state           <= ST_IDLE;
          bus.start_ready <= 1'b1;
          bus.busy        <= 1'b0;
        end

        default: begin
          state           <= ST_IDLE;
          bus.start_ready <= 1'b1;
          bus.busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dffn_chain_driver.sv
// Bench for dffn_chain_driver driving a modelled 8-stage falling-edge flop chain;
// expected words come from a word-level model of what the chain holds.
module tb_dffn_chain_driver;

  localparam int W       = 8;
  localparam int HALF    = 2;
  localparam int CLR_CYC = 4;
  localparam int SLOT    = 2 * HALF;
  localparam int RST_AT  = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         sdo;
  logic         clkn_out;
  logic         rn_out;
  logic         si;
  logic [W-1:0] chain = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Word-level expectation: what the chain holds, and the last unloaded word.
  logic [W-1:0] model_chain = '0;
  logic [W-1:0] model_dout  = '0;

  dffn_chain_if #(.WIDTH(W)) bus ();

  dffn_chain_driver #(
    .WIDTH   (W),
    .HALF    (HALF),
    .CLR_CYC (CLR_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sdo      (sdo),
    .clkn_out (clkn_out),
    .rn_out   (rn_out),
    .si       (si)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External chain: falling-edge flops with asynchronous active-low clear.
  always @(negedge clkn_out or negedge rn_out) begin
    if (!rn_out) chain <= '0;
    else         chain <= {chain[W-2:0], sdo};
  end
  assign si = chain[W-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One transfer from request to the cycle after DONE. Latency is counted as
  // the edge at which a synchronous consumer first sees DONE high.
  task automatic run_xfer(input logic [W-1:0] d, input logic c, input bit hold,
                          input logic [W-1:0] nxt, output int acc_cyc);
    int           j;
    int           lat_exp;
    int           falls;
    int           rn_low;
    bit           stable;
    bit           seen;
    logic         sdo_h  [64];
    logic         clkn_h [64];
    logic [W-1:0] exp_dout;

    j = 0;
    while (bus.start_ready !== 1'b1 && j < 100) begin
      @(posedge clk); #1;
      j++;
    end
    check("ready_before_req", 32'(bus.start_ready), 32'd1);

    bus.start_valid = 1'b1;
    bus.din         = d;
    bus.clr         = c;
    @(posedge clk); #1;
    acc_cyc = cyc;

    exp_dout    = c ? '0 : model_chain;
    model_chain = d;
    lat_exp     = (c ? CLR_CYC : 0) + W * SLOT + 1;

    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("dout_hold", 32'(bus.dout), 32'(model_dout));

    falls  = 0;
    rn_low = 0;
    stable = 1'b1;
    seen   = 1'b0;
    for (j = 0; j < 64; j++) begin
      sdo_h[j]  = sdo;
      clkn_h[j] = clkn_out;
      if (!rn_out) rn_low++;
      if (j >= 1 && clkn_h[j-1] && !clkn_h[j]) falls++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      // Requests while busy must be ignored.
      bus.start_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
      bus.din         = W'($urandom);
      bus.clr         = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end

    for (int k = 2; k + 1 <= j && k + 1 < 64; k++) begin
      if (clkn_h[k-1] && !clkn_h[k]) begin
        if (!(sdo_h[k-2] == sdo_h[k] && sdo_h[k-1] == sdo_h[k] && sdo_h[k+1] == sdo_h[k]))
          stable = 1'b0;
      end
    end

    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(j + 1), 32'(lat_exp));
    check("dout", 32'(bus.dout), 32'(exp_dout));
    check("clkn_falls", 32'(falls), 32'(W));
    check("sdo_stable", 32'(stable), 32'd1);
    check("rn_low_cycles", 32'(rn_low), c ? 32'(CLR_CYC) : 32'd0);
    model_dout = exp_dout;

    bus.start_valid = hold;
    bus.din         = nxt;
    bus.clr         = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_clear", 32'(bus.busy), 32'd0);
    check("chain_contents", 32'(chain), 32'(model_chain));
  endtask

  initial begin
    int           a1;
    int           a2;
    int           shifted;
    bit           bad;
    logic [W-1:0] rd;

    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.din         = '0;
    bus.clr         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_clkn", 32'(clkn_out), 32'd1);
    check("rst_rn", 32'(rn_out), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_ready", 32'(bus.start_ready), 32'd1);
    rst = 1'b0;

    // Preload 0x3C, then load 0xA5 and unload 0x3C.
    run_xfer(8'h3C, 1'b0, 1'b0, 8'h00, a1);
    run_xfer(8'hA5, 1'b0, 1'b0, 8'h00, a1);

    // Preload 0xFF, then clear and load 0x5A.
    run_xfer(8'hFF, 1'b0, 1'b0, 8'h00, a1);
    run_xfer(8'h5A, 1'b1, 1'b0, 8'h00, a1);

    // Back-to-back with START_VALID held.
    run_xfer(8'h01, 1'b0, 1'b1, 8'h80, a1);
    run_xfer(8'h80, 1'b0, 1'b0, 8'h00, a2);
    check("b2b_accept_gap", 32'(a2 - a1), 32'(W * SLOT + 2));

    // Abort part-way through SHIFT.
    rd              = 8'hC3;
    bus.din         = rd;
    bus.clr         = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (RST_AT) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_sdo", 32'(sdo), 32'd0);
    check("abort_clkn", 32'(clkn_out), 32'd1);
    check("abort_rn", 32'(rn_out), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_dout", 32'(bus.dout), 32'd0);
    check("abort_ready", 32'(bus.start_ready), 32'd1);
    shifted     = (RST_AT - HALF) / SLOT + 1;
    model_chain = (model_chain << shifted) | (rd >> (W - shifted));
    model_dout  = '0;
    @(posedge clk); #1;
    check("abort_chain", 32'(chain), 32'(model_chain));
    rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) bad = 1'b1;
    end
    check("abort_no_done", 32'(bad), 32'd0);
    run_xfer(8'h96, 1'b0, 1'b0, 8'h00, a1);

    // Randomised traffic.
    repeat (6) begin
      run_xfer(W'($urandom), 1'($urandom_range(0, 1)), 1'b0, 8'h00, a1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
